ps2_scancode_rx: RTL and testbench
==================================

// Module: ps2_scancode_rx
// PURPOSE
// - Receives PS/2 keyboard frames on clkps2/dataps2 and delivers decoded make/break events.
// - Sits directly upstream of the keyboard-command logic, which consumes one strobe per key event.
// - Handles the 0xE0 (extended) and 0xF0 (release) prefix bytes internally.
// - Reports parity and framing faults as single-cycle strobes.
// PARAMETERS
// - FILTER_LEN      8     clkps2 deglitch depth in clk cycles; legal range 2..16.
// - TIMEOUT_CYCLES  7000  idle clk cycles before a partial frame is aborted (1 ms at 7 MHz).
// PORTS
// - clk           in   1  system clock (7 MHz in the test design).
// - rst           in   1  asynchronous, active-high reset.
// - clkps2        in   1  raw PS/2 clock from the connector; asynchronous to clk.
// - dataps2       in   1  raw PS/2 data from the connector; asynchronous to clk.
// - scancode      out  8  last decoded code byte, prefixes stripped.
// - extended      out  1  scancode was preceded by 0xE0.
// - released      out  1  scancode was preceded by 0xF0 (break code).
// - kbd_event     out  1  1-cycle strobe: scancode/extended/released are valid and newly updated.
// - parity_error  out  1  1-cycle strobe: received frame failed odd parity.
// - frame_error   out  1  1-cycle strobe: stop bit was 0, or a timeout occurred.
// BEHAVIOUR
// Reset:
// - All outputs return to 0; FSM goes to IDLE; the prefix flags ext_p and rel_p clear.
// - The filter shift register and the filtered clock level load to 1.
// Input conditioning:
// - clkps2 and dataps2 each pass through a 2-flop synchroniser.
// - Synchronised clkps2 shifts into a FILTER_LEN shift register.
// - The filtered level goes 0 only when all FILTER_LEN taps are 0, and 1 only when all taps are 1.
// - A fall is a filtered-level transition from 1 to 0.
// - Data is sampled from the synchronised dataps2 in the cycle the fall is detected.
// FSM (advances only on a fall):
// - IDLE: data=0 -> DATA with bit count 0. Data=1 -> stay in IDLE (spurious edge).
// - DATA: shift data LSB-first. After the 8th bit -> PARITY.
// - PARITY: latch the parity bit -> STOP.
// - STOP: evaluate the frame, then -> IDLE.
// STOP evaluation (stop bit is checked first):
// - Stop bit = 0 -> frame_error pulse; byte dropped; ext_p and rel_p cleared.
// - Else, if the popcount of the 8 data bits plus the parity bit is even -> parity_error pulse; byte dropped; prefixes cleared.
// - Else byte 0xE0 -> set ext_p, no event.
// - Else byte 0xF0 -> set rel_p, no event.
// - Else: scancode<=byte, extended<=ext_p, released<=rel_p, kbd_event pulse, then clear ext_p and rel_p.
// - Any other byte, including 0xE1, is reported as an ordinary code.
// Timing:
// - Strobes assert exactly 1 clk after the cycle in which the stop-bit fall is detected.
// - Strobes are high for exactly 1 cycle.
// - scancode, extended and released hold their values until the next kbd_event.
// Boundaries:
// - At most one strobe per frame.
// - A prefix followed by an errored frame is lost.
// - The sequence 0xE0, 0xF0, code yields one event with extended=1 and released=1.
// - rst asserted mid-frame aborts the frame immediately, with no strobe.
// CONFIGURATION
// - PS2_RX_TIMEOUT_EN defined:
//   - A counter runs while the FSM is not in IDLE and clears on every fall.
//   - When it reaches TIMEOUT_CYCLES: FSM -> IDLE, frame_error pulses once, ext_p and rel_p clear.
// - PS2_RX_TIMEOUT_EN undefined:
//   - No counter is present.
//   - A partial frame waits indefinitely; realignment is only by further edges or by rst.
// TESTING
// PS/2 bit period 80 us (clkps2 low 40 us, high 40 us), FILTER_LEN=8, clk=7 MHz, macro defined except in test 6.
// - 1. Frame 0x1C, parity 0, stop 1 -> one kbd_event: scancode=0x1C, extended=0, released=0.
// - 2. Frames 0xE0, 0xF0, 0x75 -> exactly one kbd_event: scancode=0x75, extended=1, released=1; no strobe after the first two frames.
// - 3. Frame 0x1C with parity 1 -> parity_error=1 for 1 cycle, no kbd_event; then frame 0x29 -> kbd_event, scancode=0x29, flags 0.
// - 4. 3-cycle low glitches on clkps2 while in IDLE and while mid-frame -> no FSM advance; the following clean frame decodes correctly.
// - 5. 4 data bits then bus idle -> frame_error pulse 7000 clk after the last fall; then frame 0x5A -> kbd_event, scancode=0x5A.
// - 6. Macro undefined: same stimulus as test 5 -> no frame_error; rst pulse mid-frame, then frame 0x5A -> kbd_event, scancode=0x5A.

Source files
------------

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: deglitched clock, frame FSM, E0/F0 prefix decode.
// Define PS2_RX_TIMEOUT_EN to abort stalled partial frames after TIMEOUT_CYCLES.
module ps2_scancode_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 7000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clkps2,
    input  logic       dataps2,
    output logic [7:0] scancode,
    output logic       extended,
    output logic       released,
    output logic       kbd_event,
    output logic       parity_error,
    output logic       frame_error
);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic                  clk_s1, clk_s2;
    logic                  dat_s1, dat_s2;
    logic [FILTER_LEN-1:0] filt_sr;
    logic                  filt_lvl;
    logic                  fall;

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] sh_q, sh_d;
    logic       par_q, par_d;
    logic       ext_q, ext_d;
    logic       rel_q, rel_d;
    logic [7:0] code_d;
    logic       extd_d, reld_d;
    logic       ev_d, pe_d, fe_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            dat_s1   <= 1'b1;
            dat_s2   <= 1'b1;
            filt_sr  <= '1;
            filt_lvl <= 1'b1;
        end else begin
            clk_s1  <= clkps2;
            clk_s2  <= clk_s1;
            dat_s1  <= dataps2;
            dat_s2  <= dat_s1;
            filt_sr <= {filt_sr[FILTER_LEN-2:0], clk_s2};
            if (&filt_sr)
                filt_lvl <= 1'b1;
            else if (~|filt_sr)
                filt_lvl <= 1'b0;
        end
    end

    // Fall is flagged in the cycle the filter first reads all-zero.
    assign fall = filt_lvl & ~|filt_sr;

`ifdef PS2_RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] tmo_q;
    logic          tmo_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            tmo_q <= '0;
        else if (fall || state_q == IDLE)
            tmo_q <= '0;
        else
            tmo_q <= tmo_q + 1'b1;
    end

    assign tmo_hit = (state_q != IDLE) && !fall &&
                     (tmo_q == TW'(TIMEOUT_CYCLES - 1));
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        par_d   = par_q;
        ext_d   = ext_q;
        rel_d   = rel_q;
        code_d  = scancode;
        extd_d  = extended;
        reld_d  = released;
        ev_d    = 1'b0;
        pe_d    = 1'b0;
        fe_d    = 1'b0;
        if (fall) begin
            unique case (state_q)
                IDLE: begin
                    if (!dat_s2) begin
                        state_d = DATA;
                        cnt_d   = 3'd0;
                    end
                end
                DATA: begin
                    sh_d = {dat_s2, sh_q[7:1]};
                    if (cnt_q == 3'd7)
                        state_d = PARITY;
                    else
                        cnt_d = cnt_q + 3'd1;
                end
                PARITY: begin
                    par_d   = dat_s2;
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (!dat_s2) begin
                        fe_d  = 1'b1;
                        ext_d = 1'b0;
                        rel_d = 1'b0;
                    end else if (!(^{sh_q, par_q})) begin
                        pe_d  = 1'b1;
                        ext_d = 1'b0;
                        rel_d = 1'b0;
                    end else if (sh_q == 8'hE0) begin
                        ext_d = 1'b1;
                    end else if (sh_q == 8'hF0) begin
                        rel_d = 1'b1;
                    end else begin
                        code_d = sh_q;
                        extd_d = ext_q;
                        reld_d = rel_q;
                        ev_d   = 1'b1;
                        ext_d  = 1'b0;
                        rel_d  = 1'b0;
                    end
                end
            endcase
        end
`ifdef PS2_RX_TIMEOUT_EN
        else if (tmo_hit) begin
            state_d = IDLE;
            fe_d    = 1'b1;
            ext_d   = 1'b0;
            rel_d   = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 3'd0;
            sh_q         <= 8'h00;
            par_q        <= 1'b0;
            ext_q        <= 1'b0;
            rel_q        <= 1'b0;
            scancode     <= 8'h00;
            extended     <= 1'b0;
            released     <= 1'b0;
            kbd_event    <= 1'b0;
            parity_error <= 1'b0;
            frame_error  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sh_q         <= sh_d;
            par_q        <= par_d;
            ext_q        <= ext_d;
            rel_q        <= rel_d;
            scancode     <= code_d;
            extended     <= extd_d;
            released     <= reld_d;
            kbd_event    <= ev_d;
            parity_error <= pe_d;
            frame_error  <= fe_d;
        end
    end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Directed bench for ps2_scancode_rx; timeout checks follow PS2_RX_TIMEOUT_EN.
// PS/2 bit period shortened to 2*HALF clk cycles to keep runtime small.
module tb_ps2_scancode_rx;

    localparam int HALF = 24;

    logic       clk = 1'b0;
    logic       rst;
    logic       clkps2;
    logic       dataps2;
    logic [7:0] scancode;
    logic       extended;
    logic       released;
    logic       kbd_event;
    logic       parity_error;
    logic       frame_error;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int ev_cnt      = 0;
    int pe_cnt      = 0;
    int fe_cnt      = 0;
    int wide_cnt    = 0;
    int fe_cyc      = 0;
    int last_fall   = 0;
    logic ev_p = 1'b0, pe_p = 1'b0, fe_p = 1'b0;

    ps2_scancode_rx #(.FILTER_LEN(8), .TIMEOUT_CYCLES(7000)) dut (
        .clk          (clk),
        .rst          (rst),
        .clkps2       (clkps2),
        .dataps2      (dataps2),
        .scancode     (scancode),
        .extended     (extended),
        .released     (released),
        .kbd_event    (kbd_event),
        .parity_error (parity_error),
        .frame_error  (frame_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (kbd_event) ev_cnt++;
        if (parity_error) pe_cnt++;
        if (frame_error) fe_cnt++;
        if (frame_error && !fe_p) fe_cyc = cyc;
        if ((kbd_event && ev_p) || (parity_error && pe_p) ||
            (frame_error && fe_p))
            wide_cnt++;
        ev_p = kbd_event;
        pe_p = parity_error;
        fe_p = frame_error;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic glitch();
        clkps2 = 1'b0;
        tick(3);
        clkps2 = 1'b1;
        tick(HALF);
    endtask

    task automatic send_bit(input logic b);
        dataps2 = b;
        tick(HALF);
        clkps2    = 1'b0;
        last_fall = cyc;
        tick(HALF);
        clkps2 = 1'b1;
    endtask

    // glitch_after: bit index (0..10) after which a short clock glitch is injected
    task automatic send_frame(input logic [7:0] data, input logic par,
                              input logic stp, input int glitch_after);
        logic [10:0] bits;
        bits = {stp, par, data, 1'b0};
        for (int i = 0; i < 11; i++) begin
            send_bit(bits[i]);
            if (i == glitch_after) glitch();
        end
        dataps2 = 1'b1;
        tick(HALF);
    endtask

    int e0, p0, f0, lat;

    initial begin
        rst     = 1'b1;
        clkps2  = 1'b1;
        dataps2 = 1'b1;
        tick(5);
        chk("rst_scancode", 32'(scancode), 32'h00);
        chk("rst_flags", {29'd0, extended, released, kbd_event}, 32'h0);
        chk("rst_errs", {30'd0, parity_error, frame_error}, 32'h0);
        rst = 1'b0;
        tick(HALF);

        // plain code
        e0 = ev_cnt; p0 = pe_cnt; f0 = fe_cnt;
        send_frame(8'h1C, 1'b0, 1'b1, -1);
        chk("t1_events", 32'(ev_cnt - e0), 32'd1);
        chk("t1_code", 32'(scancode), 32'h1C);
        chk("t1_flags", {30'd0, extended, released}, 32'h0);
        chk("t1_errs", 32'(pe_cnt - p0 + fe_cnt - f0), 32'd0);

        // extended break sequence
        e0 = ev_cnt; p0 = pe_cnt; f0 = fe_cnt;
        send_frame(8'hE0, 1'b0, 1'b1, -1);
        send_frame(8'hF0, 1'b1, 1'b1, -1);
        chk("t2_prefix_quiet", 32'(ev_cnt - e0 + pe_cnt - p0 + fe_cnt - f0),
            32'd0);
        send_frame(8'h75, 1'b0, 1'b1, -1);
        chk("t2_events", 32'(ev_cnt - e0), 32'd1);
        chk("t2_code", 32'(scancode), 32'h75);
        chk("t2_flags", {30'd0, extended, released}, 32'h3);

        // parity fault then recovery
        e0 = ev_cnt; p0 = pe_cnt;
        send_frame(8'h1C, 1'b1, 1'b1, -1);
        chk("t3_perr", 32'(pe_cnt - p0), 32'd1);
        chk("t3_no_event", 32'(ev_cnt - e0), 32'd0);
        chk("t3_hold_code", 32'(scancode), 32'h75);
        send_frame(8'h29, 1'b0, 1'b1, -1);
        chk("t3_code", 32'(scancode), 32'h29);
        chk("t3_flags", {30'd0, extended, released}, 32'h0);

        // prefix lost to a framing fault; E1 is an ordinary code
        e0 = ev_cnt; f0 = fe_cnt;
        send_frame(8'hE0, 1'b0, 1'b1, -1);
        send_frame(8'h1C, 1'b0, 1'b0, -1);
        chk("t3b_ferr", 32'(fe_cnt - f0), 32'd1);
        send_frame(8'hE1, 1'b1, 1'b1, -1);
        chk("t3b_events", 32'(ev_cnt - e0), 32'd1);
        chk("t3b_code", 32'(scancode), 32'hE1);
        chk("t3b_ext_lost", {31'd0, extended}, 32'h0);

        // glitches while idle and mid-frame
        e0 = ev_cnt; p0 = pe_cnt; f0 = fe_cnt;
        glitch();
        send_frame(8'h5A, 1'b1, 1'b1, 4);
        chk("t4_events", 32'(ev_cnt - e0), 32'd1);
        chk("t4_errs", 32'(pe_cnt - p0 + fe_cnt - f0), 32'd0);
        chk("t4_code", 32'(scancode), 32'h5A);
        send_frame(8'h29, 1'b0, 1'b1, 7);
        chk("t4b_code", 32'(scancode), 32'h29);

        // stalled partial frame: start + 4 data bits
        e0 = ev_cnt; f0 = fe_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        dataps2 = 1'b1;
        tick(7100);
`ifdef PS2_RX_TIMEOUT_EN
        lat = fe_cyc - last_fall;
        chk("t5_timeout_ferr", 32'(fe_cnt - f0), 32'd1);
        chk("t5_latency_lo", {31'd0, lat >= 7000}, 32'd1);
        chk("t5_latency_hi", {31'd0, lat <= 7030}, 32'd1);
        send_frame(8'h5A, 1'b1, 1'b1, -1);
        chk("t5_events", 32'(ev_cnt - e0), 32'd1);
        chk("t5_code", 32'(scancode), 32'h5A);
        send_frame(8'h29, 1'b0, 1'b1, -1);
`else
        chk("t6_no_ferr", 32'(fe_cnt - f0), 32'd0);
        chk("t6_no_event", 32'(ev_cnt - e0), 32'd0);
`endif

        // reset mid-frame
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        e0 = ev_cnt; p0 = pe_cnt; f0 = fe_cnt;
        rst = 1'b1;
        tick(3);
        chk("t6_rst_code", 32'(scancode), 32'h00);
        rst = 1'b0;
        dataps2 = 1'b1;
        tick(HALF);
        chk("t6_rst_quiet", 32'(ev_cnt - e0 + pe_cnt - p0 + fe_cnt - f0),
            32'd0);
        send_frame(8'h5A, 1'b1, 1'b1, -1);
        chk("t6_events", 32'(ev_cnt - e0), 32'd1);
        chk("t6_code", 32'(scancode), 32'h5A);
        chk("t6_flags", {30'd0, extended, released}, 32'h0);

        chk("strobe_width", 32'(wide_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
